// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and encodings for the control sequencer: opcodes, ALU selects,
// the step-state encoding and the instruction classes the sequencer branches on.
package cpu_ctrl_pkg;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NEG  = 5'b10001;
    localparam logic [4:0] OPC_NOT  = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_NONE = 5'b00000;

    typedef enum logic [3:0] {
        ST_RESET, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CL_RTYPE, CL_ITYPE, CL_UNARY, CL_MULDIV, CL_LD, CL_LDI, CL_ST, CL_NOP, CL_HALT
    } opc_class_e;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps an opcode to the instruction class that selects the execute-step sequence.
// Unassigned opcodes fall into the nop class.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output opc_class_e       o_class
);

    logic [4:0] w_opc;
    assign w_opc = 5'(i_opcode);

    always_comb begin
        o_class = CL_NOP;
        case (w_opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL:    o_class = CL_RTYPE;
            OPC_ADDI, OPC_ANDI, OPC_ORI:            o_class = CL_ITYPE;
            OPC_NEG, OPC_NOT:                       o_class = CL_UNARY;
            OPC_MUL, OPC_DIV:                       o_class = CL_MULDIV;
            OPC_LD:                                 o_class = CL_LD;
            OPC_LDI:                                o_class = CL_LDI;
            OPC_ST:                                 o_class = CL_ST;
            OPC_HALT:                               o_class = CL_HALT;
            OPC_NOP:                                o_class = CL_NOP;
            default:                                o_class = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Moore control sequencer: steps T0-T7 of fetch/decode/execute, emitting one step's
// datapath control lines per clock, with memory wait steps held until mem_done.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        mem_done,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        read,
    output logic        write,
    output logic [4:0]  ALU,
    output logic        run
);

    state_e           r_state;
    state_e           w_next_state;
    opc_class_e       w_class;
    logic [OPC_W-1:0] w_opc;
    logic [4:0]       w_alu_op;
    logic             w_unused_ir;

    assign w_opc       = IR[31 -: OPC_W];
    assign w_alu_op    = 5'(w_opc);
    assign w_unused_ir = ^IR[31-OPC_W:0];

    opcode_class_decode #(.OPC_W(OPC_W)) u_decode (
        .i_opcode (w_opc),
        .o_class  (w_class)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) r_state <= ST_RESET;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = ST_T0;
        case (r_state)
            ST_RESET: w_next_state = ST_T0;
            ST_T0:    w_next_state = ST_T1;
            ST_T1:    w_next_state = mem_done ? ST_T2 : ST_T1;
            ST_T2: begin
                if (w_class == CL_NOP)       w_next_state = ST_T0;
                else if (w_class == CL_HALT) w_next_state = ST_HALT;
                else                         w_next_state = ST_T3;
            end
            ST_T3:    w_next_state = ST_T4;
            ST_T4:    w_next_state = (w_class == CL_UNARY) ? ST_T0 : ST_T5;
            ST_T5: begin
                if (w_class == CL_MULDIV || w_class == CL_LD || w_class == CL_ST)
                    w_next_state = ST_T6;
                else
                    w_next_state = ST_T0;
            end
            ST_T6: begin
                if (w_class == CL_LD)      w_next_state = mem_done ? ST_T7 : ST_T6;
                else if (w_class == CL_ST) w_next_state = ST_T7;
                else                       w_next_state = ST_T0;
            end
            ST_T7: begin
                if (w_class == CL_ST) w_next_state = mem_done ? ST_T0 : ST_T7;
                else                  w_next_state = ST_T0;
            end
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_RESET;
        endcase
    end

    always_comb begin
        {PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout} = '0;
        {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin} = '0;
        {Gra, Grb, Grc, IncPC, read, write}                   = '0;
        ALU = ALU_NONE;
        run = (r_state != ST_RESET) && (r_state != ST_HALT);
        case (r_state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1; end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                case (w_class)
                    CL_UNARY:  begin Grb = 1'b1; Rout = 1'b1; ALU = w_alu_op; Zin = 1'b1; end
                    CL_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    default:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CL_RTYPE, CL_MULDIV: begin Grc = (w_class == CL_RTYPE); Grb = (w_class == CL_MULDIV);
                                               Rout = 1'b1; ALU = w_alu_op; Zin = 1'b1; end
                    CL_ITYPE: begin Cout = 1'b1; ALU = w_alu_op; Zin = 1'b1; end
                    CL_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:  begin Cout = 1'b1; ALU = ALU_ADD; Zin = 1'b1; end
                endcase
            end
            ST_T5: begin
                Zlowout = 1'b1;
                case (w_class)
                    CL_MULDIV:   LOin = 1'b1;
                    CL_LD, CL_ST: MARin = 1'b1;
                    default:     begin Gra = 1'b1; Rin = 1'b1; end
                endcase
            end
            ST_T6: begin
                case (w_class)
                    CL_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                    CL_LD:     begin read = 1'b1; MDRin = 1'b1; end
                    default:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                endcase
            end
            ST_T7: begin
                if (w_class == CL_ST) write = 1'b1;
                else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle control-word checks against
// hand-written step tables for each instruction class, waits, halt and reset.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = '0;
    logic        mem_done = 1'b0;
    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin;
    logic Gra, Grb, Grc, IncPC, read, write, run;
    logic [4:0] ALU;
    logic [27:0] ctl;

    int total = 0;
    int bad   = 0;

    localparam logic [27:0] M_RUN = 28'd1 << 5,  M_WRITE = 28'd1 << 6,  M_READ = 28'd1 << 7;
    localparam logic [27:0] M_INCPC = 28'd1 << 8, M_GRC = 28'd1 << 9,   M_GRB = 28'd1 << 10;
    localparam logic [27:0] M_GRA = 28'd1 << 11, M_RIN = 28'd1 << 12,   M_LOIN = 28'd1 << 13;
    localparam logic [27:0] M_HIIN = 28'd1 << 14, M_ZIN = 28'd1 << 15,  M_YIN = 28'd1 << 16;
    localparam logic [27:0] M_IRIN = 28'd1 << 17, M_MDRIN = 28'd1 << 18, M_MARIN = 28'd1 << 19;
    localparam logic [27:0] M_PCIN = 28'd1 << 20, M_ROUT = 28'd1 << 21, M_BAOUT = 28'd1 << 22;
    localparam logic [27:0] M_COUT = 28'd1 << 23, M_MDROUT = 28'd1 << 24, M_ZHI = 28'd1 << 25;
    localparam logic [27:0] M_ZLO = 28'd1 << 26, M_PCOUT = 28'd1 << 27;

    localparam logic [27:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam logic [27:0] E_T1 = M_ZLO | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [27:0] E_T2 = M_MDROUT | M_IRIN | M_RUN;
    localparam logic [27:0] E_BA = M_GRB | M_BAOUT | M_YIN | M_RUN;
    localparam logic [27:0] E_CADD = M_COUT | M_ZIN | M_RUN | 28'd3;

    control_unit #(.OPC_W(5)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_done(mem_done),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .read(read),
        .write(write), .ALU(ALU), .run(run)
    );

    assign ctl = {PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout, PCin, MARin, MDRin,
                  IRin, Yin, Zin, HIin, LOin, Rin, Gra, Grb, Grc, IncPC, read, write, run, ALU};

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the DUT sampled in its first T0 with the given IR applied.
    task automatic do_reset(input logic [31:0] ir);
        @(negedge clock);
        clear = 1'b0;
        IR = ir;
        mem_done = 1'b1;
        @(negedge clock);
        clear = 1'b1;
        step();
    endtask

    task automatic test_reset();
        clear = 1'b0;
        mem_done = 1'b1;
        #2;
        total++;
        if (ctl !== 28'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", ctl, 28'd0); end
        repeat (3) step();
        total++;
        if (ctl !== 28'd0) begin bad++; $display("FAIL reset_edges got=%h want=%h", ctl, 28'd0); end
        @(negedge clock);
        clear = 1'b1;
        step();
        total++;
        if (ctl !== E_T0) begin bad++; $display("FAIL reset_release got=%h want=%h", ctl, E_T0); end
    endtask

    task automatic test_rtype();
        logic [27:0] ex [7];
        ex = '{E_T0, E_T1, E_T2, M_GRB | M_ROUT | M_YIN | M_RUN,
               M_GRC | M_ROUT | M_ZIN | M_RUN | 28'd5, M_ZLO | M_GRA | M_RIN | M_RUN, E_T0};
        do_reset(32'h28918000);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL rtype_and cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
    endtask

    task automatic test_ld();
        logic [27:0] ex [11];
        logic        md [11];
        ex = '{E_T0, E_T1, E_T2, E_BA, E_CADD, M_ZLO | M_MARIN | M_RUN,
               M_READ | M_MDRIN | M_RUN, M_READ | M_MDRIN | M_RUN, M_READ | M_MDRIN | M_RUN,
               M_MDROUT | M_GRA | M_RIN | M_RUN, E_T0};
        md = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(32'h00800055);
        for (int i = 0; i < 11; i++) begin
            mem_done = md[i];
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL ld_wait cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
    endtask

    task automatic test_fetch_wait();
        logic [27:0] ex [7];
        logic        md [7];
        ex = '{E_T0, E_T1, E_T1, E_T1, E_T1, E_T2, E_T0};
        md = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(32'hD0000000);
        for (int i = 0; i < 7; i++) begin
            mem_done = md[i];
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL fetch_wait cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
    endtask

    task automatic test_mul();
        logic [27:0] ex [8];
        ex = '{E_T0, E_T1, E_T2, M_GRA | M_ROUT | M_YIN | M_RUN,
               M_GRB | M_ROUT | M_ZIN | M_RUN | 28'd15, M_ZLO | M_LOIN | M_RUN,
               M_ZHI | M_HIIN | M_RUN, E_T0};
        do_reset(32'h79000000);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL mul cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
    endtask

    task automatic test_st();
        logic [27:0] ex [10];
        logic        md [10];
        ex = '{E_T0, E_T1, E_T2, E_BA, E_CADD, M_ZLO | M_MARIN | M_RUN,
               M_GRA | M_ROUT | M_MDRIN | M_RUN, M_WRITE | M_RUN, M_WRITE | M_RUN, E_T0};
        md = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset(32'h10000000);
        for (int i = 0; i < 10; i++) begin
            mem_done = md[i];
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL st_wait cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
    endtask

    task automatic test_halt();
        logic [27:0] ex [3];
        ex = '{E_T0, E_T1, E_T2};
        do_reset(32'hD8000000);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL halt_fetch cyc=%0d got=%h want=%h", i, ctl, ex[i]); end
            step();
        end
        for (int k = 0; k < 20; k++) begin
            mem_done = k[0];
            total++;
            if (ctl !== 28'd0) begin bad++; $display("FAIL halt_hold cyc=%0d got=%h want=%h", k, ctl, 28'd0); end
            step();
        end
    endtask

    task automatic test_clear_mid();
        do_reset(32'h18000000);
        repeat (4) step();
        total++;
        if (ctl !== (M_GRC | M_ROUT | M_ZIN | M_RUN | 28'd3))
            begin bad++; $display("FAIL clear_pre got=%h want=%h", ctl, M_GRC | M_ROUT | M_ZIN | M_RUN | 28'd3); end
        #1 clear = 1'b0;
        #1;
        total++;
        if (ctl !== 28'd0) begin bad++; $display("FAIL clear_async got=%h want=%h", ctl, 28'd0); end
        #1 clear = 1'b1;
        step();
        total++;
        if (ctl !== E_T0) begin bad++; $display("FAIL clear_restart got=%h want=%h", ctl, E_T0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] irs [7];
        int          lat [7];
        int          n;
        irs = '{32'hD0000000, 32'h88000000, 32'h60000000, 32'h08000000,
                32'hA0000000, 32'h10000000, 32'h80000000};
        lat = '{3, 5, 6, 6, 3, 8, 7};
        for (int j = 0; j < 7; j++) begin
            do_reset(irs[j]);
            n = 0;
            for (int k = 1; k <= 20; k++) begin
                step();
                if (ctl == E_T0) begin n = k; break; end
            end
            total++;
            if (n != lat[j]) begin bad++; $display("FAIL latency ir=%h got=%0d want=%0d", irs[j], n, lat[j]); end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_ld();
        test_fetch_wait();
        test_mul();
        test_st();
        test_halt();
        test_clear_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Moore-style control sequencer that drives the datapath (`Bus`) control lines over the fetch/decode/execute steps T0–T7. It sits directly upstream of the datapath and replaces the hand-sequenced stimulus used in datapath bring-up. It reads the IR and the memory-done handshake, and produces one step's worth of control signals per clock. Register selection uses the Gra/Grb/Grc/Rin/Rout/BAout convention; the separate select-and-encode logic expands these to R0..R15 in/out.

## Interface
- `OPC_W`, default 5: opcode width; the opcode is `IR[31:27]`.
- `clock`, input, 1: single system clock; all state changes on the rising edge.
- `clear`, input, 1: asynchronous, active-low reset.
- `IR`, input, 32: instruction register contents; only `IR[31:27]` is decoded.
- `mem_done`, input, 1: memory completion; sampled on the rising edge during memory wait steps.
- `PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout`, outputs, 1 each: bus drivers.
- `PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin`, outputs, 1 each: register loads.
- `Gra, Grb, Grc`, outputs, 1 each: register-field selects.
- `IncPC, read, write`, outputs, 1 each: PC increment and memory strobes.
- `ALU`, output, 5: ALU operation select.
- `run`, output, 1: high while executing, low in RESET and HALT.

## Operation
- Opcodes (constants):
  - ld=00000, ldi=00001, st=00010
  - add=00011, sub=00100, and=00101, or=00110, ror=00111, rol=01000, shr=01001, shra=01010, shl=01011
  - addi=01100, andi=01101, ori=01110
  - mul=01111, div=10000, neg=10001, not=10010
  - nop=11010, halt=11011
  - every other code executes as nop.
- ALU select encoding equals the opcode value. Address and immediate adds use ALU=00011.
- Outputs are a pure function of the state and `IR[31:27]`. Any signal not listed for a step is 0. ALU=00000 when unused.
- States: RESET, T0–T7, HALT.
- Fetch, all instructions:
  - T0: PCout, MARin, IncPC, Zin
  - T1: Zlowout, PCin, read, MDRin (wait state)
  - T2: MDRout, IRin
- Execute steps by instruction class:
  - R-type (add through shl): T3 Grb,Rout,Yin → T4 Grc,Rout,ALU,Zin → T5 Zlowout,Gra,Rin
  - I-type (addi/andi/ori): T3 Grb,Rout,Yin → T4 Cout,ALU,Zin → T5 Zlowout,Gra,Rin
  - neg/not: T3 Grb,Rout,ALU,Zin → T4 Zlowout,Gra,Rin
  - mul/div: T3 Gra,Rout,Yin → T4 Grb,Rout,ALU,Zin → T5 Zlowout,LOin → T6 Zhighout,HIin
  - ldi: T3 Grb,BAout,Yin → T4 Cout,ALU=00011,Zin → T5 Zlowout,Gra,Rin
  - ld: ldi steps T3–T4 → T5 Zlowout,MARin → T6 read,MDRin (wait) → T7 MDRout,Gra,Rin
  - st: ld steps T3–T5 → T6 Gra,Rout,MDRin (read=0) → T7 write (wait)
  - nop: T2 → T0
  - halt: T2 → HALT; HALT is held until `clear` is asserted, with all outputs 0 and run=0.
- After an instruction's last step, the next state is T0.

## Timing
- Reset: `clear` low forces state RESET immediately, independent of the clock, in any state including mid-instruction or a wait state.
  - All outputs are 0 and run=0 while `clear` is low.
- The first rising edge with `clear` high moves RESET → T0, and run becomes 1.
- Every step lasts exactly one clock, except the wait steps (T1; T6 of ld; T7 of st).
- Wait steps: the state advances on the first rising edge where `mem_done`=1. Strobes stay asserted for the whole wait.
- `mem_done` high on the entry cycle of a wait step gives a single-cycle step. `mem_done` outside wait steps is ignored.
- Zero-wait latency, fetch included:
  - 3 cycles: nop
  - 5 cycles: neg/not
  - 6 cycles: R-type, I-type, ldi
  - 7 cycles: mul/div
  - 8 cycles: ld, st
- `IR` must be stable from T3 to the end of the instruction; it changes only via IRin at T2.

## Structure
- Package `cpu_ctrl_pkg`: opcode localparams, the ALU_ADD constant, the state encoding (RESET, T0–T7, HALT), and the instruction-class enumeration.
- One sub-module, `opcode_class_decode`, which maps the opcode to a class: RTYPE, ITYPE, UNARY, MULDIV, LD, LDI, ST, NOP, HALT.
- The control_unit itself holds only the state register, the next-state logic and the output decode.

## Test plan
- IR=0x28918000 (and R1,R2,R3), mem_done tied 1.
  - Expect T3 Grb+Rout+Yin, T4 Grc+Rout+ALU=00101+Zin, T5 Zlowout+Gra+Rin.
  - Next instruction's T0 arrives 6 cycles after the first T0.
- IR=0x00800055 (ld R1,0x55(R0)), mem_done held low 2 cycles in T6.
  - Expect read+MDRin asserted for 3 cycles, T7 MDRout+Gra+Rin, total 10 cycles.
- mem_done low for 3 cycles in T1.
  - Expect PCin, read, MDRin and Zlowout held for 4 cycles; IRin only in the following cycle.
- IR=0x79000000 (mul).
  - Expect T5 LOin with Zlowout, then T6 HIin with Zhighout, ALU=01111 at T4.
- IR=0xD8000000 (halt).
  - After T2, run=0 and all outputs stay 0 for 20 cycles regardless of mem_done.
- clear pulsed low during T4 of an add.
  - Expect all outputs 0 within the same cycle, run=0.
  - After release, T0 (PCout, MARin, IncPC, Zin) on the next edge.
